// File: rtl/nv_nvdla_sdp_rdma_dat_rsp.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_sdp_rdma_dat_rsp
// Brief    : SDP RDMA read-data return path. Buffers DMA response beats, returns
//            credits and replays the beats to the SDP datapath in command-sized groups.
// Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_sdp_rdma_dat_rsp #(
  parameter int LAT_DEPTH = 16,
  parameter int DW        = 64
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          op_load,
  input  logic          cmd2dat_pvld,
  output logic          cmd2dat_prdy,
  input  logic [13:0]   cmd2dat_pd,
  input  logic          dma_rd_rsp_vld,
  output logic          dma_rd_rsp_rdy,
  input  logic [DW-1:0] dma_rd_rsp_pd,
  output logic          dma_rd_cdt_lat_fifo_pop,
  output logic          sdp_rdma2dp_valid,
  input  logic          sdp_rdma2dp_ready,
  output logic [DW:0]   sdp_rdma2dp_pd,
  output logic          dp2reg_done,
  output logic [31:0]   dp2reg_rdma_stall
);

  localparam int AW = $clog2(LAT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL_CNT = CW'(LAT_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t          r_state;
  logic [13:0]     r_len;
  logic [13:0]     r_beat_cnt;
  logic            r_surf_last;
  logic            r_done;
  logic            r_cdt;
  logic [31:0]     r_stall;

  logic [DW-1:0]   r_mem [LAT_DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic            w_last;

  // Ready depends only on the registered count, never on the pop in flight.
  assign w_full   = (r_cnt == C_FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_push   = dma_rd_rsp_vld & ~w_full;
  assign w_valid  = (r_state == ST_ACTIVE) & ~w_empty;
  assign w_pop    = w_valid & sdp_rdma2dp_ready;
  assign w_last   = (r_beat_cnt == (r_len - 14'd1));

  assign dma_rd_rsp_rdy          = ~w_full;
  assign cmd2dat_prdy            = (r_state == ST_IDLE);
  assign sdp_rdma2dp_valid       = w_valid;
  assign sdp_rdma2dp_pd          = w_valid ? {w_last, r_mem[r_rp]} : '0;
  assign dma_rd_cdt_lat_fifo_pop = r_cdt;
  assign dp2reg_done             = r_done;
  assign dp2reg_rdma_stall       = r_stall;

  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) begin
      r_mem[r_wp] <= dma_rd_rsp_pd;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Command FSM; 14-bit length holds 8192 without overflow.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_surf_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd2dat_pvld) begin
            r_len       <= {1'b0, cmd2dat_pd[12:0]} + 14'd1;
            r_surf_last <= cmd2dat_pd[13];
            r_beat_cnt  <= '0;
            r_state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 14'd1;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= r_surf_last;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_cdt   <= 1'b0;
      r_stall <= '0;
    end else begin
      r_cdt <= w_pop;
      if (op_load) begin
        r_stall <= '0;
      end else if (w_valid && !sdp_rdma2dp_ready && (r_stall != 32'hFFFF_FFFF)) begin
        r_stall <= r_stall + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_sdp_rdma_dat_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_nvdla_sdp_rdma_dat_rsp
// Brief    : Directed self-checking bench for the SDP RDMA data return path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_sdp_rdma_dat_rsp;

  logic        clk;
  logic        rst_n;
  logic        op_load;
  logic        cmd_pvld;
  logic        cmd_prdy;
  logic [13:0] cmd_pd;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [63:0] rsp_pd;
  logic        cdt;
  logic        dp_valid;
  logic        dp_ready;
  logic [64:0] dp_pd;
  logic        done;
  logic [31:0] stall;

  int n_vec = 0;
  int n_err = 0;

  nv_nvdla_sdp_rdma_dat_rsp #(.LAT_DEPTH(16), .DW(64)) u_dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rstn         (rst_n),
    .op_load                 (op_load),
    .cmd2dat_pvld            (cmd_pvld),
    .cmd2dat_prdy            (cmd_prdy),
    .cmd2dat_pd              (cmd_pd),
    .dma_rd_rsp_vld          (rsp_vld),
    .dma_rd_rsp_rdy          (rsp_rdy),
    .dma_rd_rsp_pd           (rsp_pd),
    .dma_rd_cdt_lat_fifo_pop (cdt),
    .sdp_rdma2dp_valid       (dp_valid),
    .sdp_rdma2dp_ready       (dp_ready),
    .sdp_rdma2dp_pd          (dp_pd),
    .dp2reg_done             (done),
    .dp2reg_rdma_stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] q[$];
    logic [63:0] data;
    logic [63:0] head;
    logic        v;
    logic        r;
    logic        do_push;
    logic        do_pop;
    int          cnt;
    int          pushed;
    int          popped;
    int          cdt_tot;
    int          cyc;

    rst_n = 1'b0; op_load = 1'b0; cmd_pvld = 1'b0; cmd_pd = '0;
    rsp_vld = 1'b0; rsp_pd = '0; dp_ready = 1'b0;
    tick(); tick();
    chk("rst_rsp_rdy", rsp_rdy, 1'b1);
    chk("rst_cmd_prdy", cmd_prdy, 1'b1);
    chk("rst_valid", dp_valid, 1'b0);
    chk("rst_pd", dp_pd, '0);
    chk("rst_cdt", cdt, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, '0);
    rst_n = 1'b1;

    // Single 4-beat surface-final command
    tick();
    cmd_pvld = 1'b1; cmd_pd = {1'b1, 13'd3};
    rsp_vld = 1'b1; rsp_pd = 64'h0; dp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", dp_valid, 1'b1);
      chk("t1_pd", dp_pd, {(i == 3), 64'(i)});
      if (i > 0) chk("t1_cdt", cdt, 1'b1);
      if (i == 0) begin
        chk("t1_prdy", cmd_prdy, 1'b0);
        cmd_pvld = 1'b0;
      end
      if (i < 3) rsp_pd = 64'(i + 1);
      else rsp_vld = 1'b0;
    end
    tick();
    chk("t1_end_valid", dp_valid, 1'b0);
    chk("t1_done", done, 1'b1);
    chk("t1_cdt4", cdt, 1'b1);
    chk("t1_prdy_back", cmd_prdy, 1'b1);
    tick();
    chk("t1_done_once", done, 1'b0);
    chk("t1_cdt_off", cdt, 1'b0);

    // Fill the FIFO while idle, then drain 16 beats
    for (int i = 0; i < 16; i++) begin
      chk("t2_fill_rdy", rsp_rdy, 1'b1);
      rsp_vld = 1'b1; rsp_pd = 64'h100 + 64'(i);
      tick();
      chk("t2_fill_novalid", dp_valid, 1'b0);
    end
    rsp_vld = 1'b0;
    chk("t2_full_rdy", rsp_rdy, 1'b0);
    cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd15};
    tick();
    cmd_pvld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_valid", dp_valid, 1'b1);
      chk("t2_pd", dp_pd, {(i == 15), 64'h100 + 64'(i)});
      if (i == 0) chk("t2_rdy_full", rsp_rdy, 1'b0);
      if (i == 1) chk("t2_rdy_back", rsp_rdy, 1'b1);
      tick();
    end
    chk("t2_end_valid", dp_valid, 1'b0);
    chk("t2_no_done", done, 1'b0);

    // Back-to-back 2-beat and 3-beat commands
    for (int i = 0; i < 5; i++) begin
      rsp_vld = 1'b1; rsp_pd = 64'h200 + 64'(i);
      tick();
    end
    rsp_vld = 1'b0;
    cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd1};
    tick();
    chk("t3_b1", dp_pd, {1'b0, 64'h200});
    cmd_pd = {1'b1, 13'd2};
    tick();
    chk("t3_b2", dp_pd, {1'b1, 64'h201});
    tick();
    chk("t3_bubble_valid", dp_valid, 1'b0);
    chk("t3_bubble_prdy", cmd_prdy, 1'b1);
    chk("t3_no_done_mid", done, 1'b0);
    tick();
    cmd_pvld = 1'b0;
    chk("t3_b3", dp_pd, {1'b0, 64'h202});
    tick();
    chk("t3_b4", dp_pd, {1'b0, 64'h203});
    tick();
    chk("t3_b5", dp_pd, {1'b1, 64'h204});
    chk("t3_done_early", done, 1'b0);
    tick();
    chk("t3_done", done, 1'b1);
    chk("t3_end_valid", dp_valid, 1'b0);
    tick();
    chk("t3_done_once", done, 1'b0);

    // Stall counting, hold stability, op_load clear
    cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd0};
    rsp_vld = 1'b1; rsp_pd = 64'h300; dp_ready = 1'b0;
    tick();
    cmd_pvld = 1'b0; rsp_vld = 1'b0;
    chk("t4_stall0", stall, 32'd0);
    chk("t4_pd", dp_pd, {1'b1, 64'h300});
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t4_hold_valid", dp_valid, 1'b1);
      chk("t4_hold_pd", dp_pd, {1'b1, 64'h300});
    end
    chk("t4_stall7", stall, 32'd7);
    op_load = 1'b1;
    tick();
    op_load = 1'b0;
    chk("t4_opload_clr", stall, 32'd0);
    dp_ready = 1'b1;
    tick();
    chk("t4_popped", dp_valid, 1'b0);
    chk("t4_cdt", cdt, 1'b1);
    chk("t4_stall_after", stall, 32'd0);

    // Randomised flow, 1000 beats, with push+pop at count 15
    cmd_pvld = 1'b1; cmd_pd = {1'b0, 13'd999};
    tick();
    cmd_pvld = 1'b0;
    cnt = 0; pushed = 0; popped = 0; cdt_tot = 0; cyc = 0;
    while (popped < 1000 && cyc < 20000) begin
      if (cdt) cdt_tot++;
      chk("rnd_rdy", rsp_rdy, (cnt != 16));
      chk("rnd_valid", dp_valid, (cnt != 0));
      if (cyc < 15)       begin v = 1'b1; r = 1'b0; end
      else if (cyc == 15) begin v = 1'b1; r = 1'b1; end
      else if (cyc == 16) begin v = 1'b1; r = 1'b0; end
      else begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
      end
      if (pushed >= 1000) v = 1'b0;
      data = {$urandom, $urandom};
      rsp_vld = v; rsp_pd = data; dp_ready = r;
      do_push = v && (cnt != 16);
      do_pop  = r && (cnt != 0);
      if (do_pop) begin
        head = q.pop_front();
        chk("rnd_pd", dp_pd, {(popped == 999), head});
        popped++;
      end
      if (do_push) begin
        q.push_back(data);
        pushed++;
      end
      cnt = cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      cyc++;
      tick();
    end
    chk("rnd_beats", 65'(popped), 65'd1000);
    rsp_vld = 1'b0;
    if (cdt) cdt_tot++;
    chk("rnd_cdt_total", 65'(cdt_tot), 65'd1000);
    chk("rnd_end_valid", dp_valid, 1'b0);
    chk("rnd_no_done", done, 1'b0);

    // Reset mid-command with 5 beats buffered
    dp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rsp_vld = 1'b1; rsp_pd = 64'h400 + 64'(i);
      tick();
    end
    rsp_vld = 1'b0;
    cmd_pvld = 1'b1; cmd_pd = {1'b1, 13'd7};
    tick();
    cmd_pvld = 1'b0;
    chk("t6_pre_valid", dp_valid, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rsp_rdy", rsp_rdy, 1'b1);
    chk("t6_rst_prdy", cmd_prdy, 1'b1);
    chk("t6_rst_valid", dp_valid, 1'b0);
    chk("t6_rst_pd", dp_pd, '0);
    chk("t6_rst_cdt", cdt, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_stall", stall, '0);
    tick(); tick();
    rst_n = 1'b1;
    cmd_pvld = 1'b1; cmd_pd = {1'b1, 13'd0};
    tick();
    cmd_pvld = 1'b0;
    chk("t6_fifo_empty", dp_valid, 1'b0);
    chk("t6_active", cmd_prdy, 1'b0);
    rsp_vld = 1'b1; rsp_pd = 64'h5A5; dp_ready = 1'b1;
    tick();
    rsp_vld = 1'b0;
    chk("t6_pd", dp_pd, {1'b1, 64'h5A5});
    tick();
    chk("t6_done", done, 1'b1);
    chk("t6_cdt", cdt, 1'b1);
    chk("t6_end_valid", dp_valid, 1'b0);
    chk("t6_prdy", cmd_prdy, 1'b1);
    tick();
    chk("t6_done_once", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
